// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared FSM encoding, ASCII constants and digit encoder for the
//               UART voltage-report frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_ascii_c     = 8'h43;
    localparam logic [7:0] c_ascii_eq    = 8'h3D;
    localparam logic [7:0] c_ascii_dot   = 8'h2E;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;
    localparam logic [7:0] c_ascii_qmark = 8'h3F;
    localparam logic [7:0] c_ascii_zero  = 8'h30;

    localparam int REC_LEN = 11;

    // Corrupt BCD nibbles are shown as '?' so a bad reading stays visible.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
        return (nib <= 4'd9) ? (c_ascii_zero + {4'h0, nib}) : c_ascii_qmark;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_scheduler_if
// Description : Write port into the UART transmit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_scheduler_if;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_full;

    modport master (output wr_uart, output w_data, input tx_full);
    modport slave  (input wr_uart, input w_data, output tx_full);
endinterface
`default_nettype wire

// File: rtl/uart_frame_scheduler_period_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : period_tick_gen
// Description : Free-running 0..PERIOD-1 counter; tick while at PERIOD-1.
// Revision    : 1.0 - initial release
// ============================================================================
module period_tick_gen #(
    parameter int PERIOD = 65_000_000
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      tick
);
    localparam int              CNT_W  = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_scheduler
// Description : Periodically snapshots N_CH BCD voltages and streams them as
//               "Cnn=d.ddd\r\n" records into the UART transmit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int N_CH   = 13,
    parameter int PERIOD = 65_000_000
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  enable,
    input  wire logic [16*N_CH-1:0]    ch_bcd,
    uart_frame_scheduler_if.master     uart,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);
    localparam logic [6:0] c_last_ch   = 7'(N_CH - 1);
    localparam logic [3:0] c_last_byte = 4'(REC_LEN - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_tick;
    logic [16*N_CH-1:0]   r_snap;
    logic [6:0]           r_ch_idx;
    logic [3:0]           r_ch_tens;
    logic [3:0]           r_ch_ones;
    logic [3:0]           r_byte_idx;
    logic                 r_overrun;
    logic                 w_wr;
    logic [7:0]           w_byte;
    logic [15:0]          w_cur;
    logic                 w_last_byte;
    logic                 w_last_ch;

    period_tick_gen #(
        .PERIOD (PERIOD)
    ) u_period_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_cur       = r_snap[{r_ch_idx, 4'b0000} +: 16];
    assign w_last_byte = (r_byte_idx == c_last_byte);
    assign w_last_ch   = (r_ch_idx == c_last_ch);

    always_comb begin
        w_byte = 8'h00;
        case (r_byte_idx)
            4'd0:    w_byte = c_ascii_c;
            4'd1:    w_byte = bcd_to_ascii(r_ch_tens);
            4'd2:    w_byte = bcd_to_ascii(r_ch_ones);
            4'd3:    w_byte = c_ascii_eq;
            4'd4:    w_byte = bcd_to_ascii(w_cur[15:12]);
            4'd5:    w_byte = c_ascii_dot;
            4'd6:    w_byte = bcd_to_ascii(w_cur[11:8]);
            4'd7:    w_byte = bcd_to_ascii(w_cur[7:4]);
            4'd8:    w_byte = bcd_to_ascii(w_cur[3:0]);
            4'd9:    w_byte = c_ascii_cr;
            4'd10:   w_byte = c_ascii_lf;
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && enable) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_wr = !uart.tx_full;
                if (w_wr && w_last_byte && w_last_ch) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Channel number is kept as a BCD pair so no divider is needed for "nn".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ch_idx   <= '0;
            r_ch_tens  <= '0;
            r_ch_ones  <= '0;
            r_byte_idx <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (r_state == ST_LATCH) begin
                r_ch_idx   <= '0;
                r_ch_tens  <= '0;
                r_ch_ones  <= '0;
                r_byte_idx <= '0;
            end else if (w_wr) begin
                if (w_last_byte) begin
                    r_byte_idx <= '0;
                    r_ch_idx   <= r_ch_idx + 1'b1;
                    if (r_ch_ones == 4'd9) begin
                        r_ch_ones <= '0;
                        r_ch_tens <= r_ch_tens + 1'b1;
                    end else begin
                        r_ch_ones <= r_ch_ones + 1'b1;
                    end
                end else begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_LATCH) begin
            r_snap <= ch_bcd;
        end
    end

    assign uart.wr_uart = w_wr;
    assign uart.w_data  = (r_state == ST_SEND) ? w_byte : 8'h00;
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = (r_state == ST_DONE);
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_scheduler
// Description : Directed self-checking bench for uart_frame_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_scheduler;
    localparam int N_CH      = 13;
    localparam int FRAME_LEN = 143;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst    = 1'b1;
    logic                 rst_b  = 1'b1;
    logic                 enable = 1'b0;
    logic [16*N_CH-1:0]   ch_bcd;
    logic                 busy, frame_done, overrun;
    logic                 busy_b, frame_done_b, overrun_b;

    uart_frame_scheduler_if u_if ();
    uart_frame_scheduler_if u_if_b ();

    uart_frame_scheduler #(.N_CH(N_CH), .PERIOD(400)) dut (
        .clk (clk), .rst (rst), .enable (enable), .ch_bcd (ch_bcd),
        .uart (u_if.master), .busy (busy), .frame_done (frame_done), .overrun (overrun)
    );

    uart_frame_scheduler #(.N_CH(N_CH), .PERIOD(100)) dut_b (
        .clk (clk), .rst (rst_b), .enable (1'b1), .ch_bcd (ch_bcd),
        .uart (u_if_b.master), .busy (busy_b), .frame_done (frame_done_b), .overrun (overrun_b)
    );

    logic [15:0] ch_val [N_CH];
    logic [7:0]  cap_q [$];
    logic [7:0]  q_b [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] dig(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [7:0] exp_at(input int idx);
        int          ch;
        int          b;
        logic [15:0] v;
        ch = idx / 11;
        b  = idx % 11;
        v  = ch_val[ch];
        case (b)
            0:       return 8'h43;
            1:       return 8'(48 + ch / 10);
            2:       return 8'(48 + ch % 10);
            3:       return 8'h3D;
            4:       return dig(v[15:12]);
            5:       return 8'h2E;
            6:       return dig(v[11:8]);
            7:       return dig(v[7:4]);
            8:       return dig(v[3:0]);
            9:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic pack_ch();
        for (int k = 0; k < N_CH; k++) ch_bcd[16*k +: 16] = ch_val[k];
    endtask

    task automatic check_frame(input string tag, input logic [7:0] q[$], input int n_exp);
        check($sformatf("%s_len", tag), q.size(), n_exp);
        for (int i = 0; i < q.size() && i < n_exp; i++)
            check($sformatf("%s_byte%0d", tag, i), q[i], exp_at(i));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_wr_uart"}, u_if.wr_uart, 1'b0);
        check({tag, "_w_data"}, u_if.w_data, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    // One iteration per clock: drive after posedge, sample at negedge.
    task automatic capture(input int stall_at, input int stall_len, input bit scramble,
                           input bit drop_en, input int abort_at,
                           output int first_lat, output int nbytes, output int nfd);
        int stalled;
        int busy_at;
        first_lat = -1; nbytes = 0; nfd = 0; stalled = 0; busy_at = -1;
        cap_q.delete();
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk); #1;
            if (drop_en && busy_at >= 0 && i == busy_at + 3) enable = 1'b0;
            u_if.tx_full = (stall_len > 0 && nbytes == stall_at && stalled < stall_len);
            if (u_if.tx_full) stalled++;
            @(negedge clk);
            if (busy && busy_at < 0) busy_at = i;
            if (u_if.tx_full) begin
                check("stall_no_write", u_if.wr_uart, 1'b0);
                check("stall_hold_data", u_if.w_data, exp_at(stall_at));
            end
            if (u_if.wr_uart) begin
                if (first_lat < 0) first_lat = i;
                cap_q.push_back(u_if.w_data);
                nbytes++;
                if (scramble && nbytes == 1) ch_bcd = '1;
            end
            if (frame_done) begin
                nfd++;
                break;
            end
            if (abort_at > 0 && nbytes == abort_at) break;
        end
        u_if.tx_full = 1'b0;
    endtask

    task automatic after_done(input string tag);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_busy_fell"}, busy, 1'b0);
        check({tag, "_done_one_cycle"}, frame_done, 1'b0);
    endtask

    initial begin
        int lat, nb, nfd, nw, nbz, f1lat, f2lat, nfd_b;
        logic [7:0] rec0 [11];
        logic [7:0] rec5 [11];
        rec0 = '{8'h43, 8'h30, 8'h30, 8'h3D, 8'h31, 8'h2E, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        rec5 = '{8'h43, 8'h30, 8'h35, 8'h3D, 8'h31, 8'h2E, 8'h3F, 8'h30, 8'h39, 8'h0D, 8'h0A};
        for (int k = 0; k < N_CH; k++) ch_val[k] = 16'h4000 | 16'(((k / 10) << 4) | (k % 10));
        ch_val[0]  = 16'h1234;
        ch_val[5]  = 16'h1A09;
        ch_val[12] = 16'hF999;
        pack_ch();
        u_if.tx_full   = 1'b0;
        u_if_b.tx_full = 1'b0;
        enable = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1 rst = 1'b0;

        // Frame 1: unstalled reference
        capture(-1, 0, 1'b0, 1'b0, 0, lat, nb, nfd);
        check("f1_first_write_cycle", lat, 401);
        check("f1_frame_done", nfd, 1);
        check_frame("f1", cap_q, FRAME_LEN);
        for (int i = 0; i < 11 && i + 55 < cap_q.size(); i++) begin
            check($sformatf("ch0_rec%0d", i), cap_q[i], rec0[i]);
            check($sformatf("ch5_rec%0d", i), cap_q[55 + i], rec5[i]);
        end
        after_done("f1");
        check("f1_overrun", overrun, 1'b0);

        // Frame 2: 5-cycle stall at byte 20, inputs scrambled after snapshot
        capture(20, 5, 1'b1, 1'b0, 0, lat, nb, nfd);
        pack_ch();
        check("f2_frame_done", nfd, 1);
        check_frame("f2", cap_q, FRAME_LEN);
        after_done("f2");
        check("f2_overrun", overrun, 1'b0);

        // Enable low for two periods
        enable = 1'b0;
        nw = 0; nbz = 0;
        repeat (850) begin
            @(negedge clk);
            if (u_if.wr_uart) nw++;
            if (busy) nbz++;
        end
        check("en_low_writes", nw, 0);
        check("en_low_busy", nbz, 0);
        enable = 1'b1;
        capture(-1, 0, 1'b0, 1'b1, 0, lat, nb, nfd);
        check("f3_frame_done", nfd, 1);
        check_frame("f3", cap_q, FRAME_LEN);
        nw = 0;
        repeat (900) begin
            @(negedge clk);
            if (u_if.wr_uart) nw++;
        end
        check("en_dropped_writes", nw, 0);

        // Reset mid-frame at byte 50
        enable = 1'b1;
        capture(-1, 0, 1'b0, 1'b0, 50, lat, nb, nfd);
        check("f4_bytes_before_rst", nb, 50);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        capture(-1, 0, 1'b0, 1'b0, 0, lat, nb, nfd);
        check("f5_first_write_cycle", lat, 401);
        check("f5_frame_done", nfd, 1);
        check_frame("f5", cap_q, FRAME_LEN);

        // PERIOD=100: second tick lands mid-frame
        @(posedge clk); #1 rst_b = 1'b0;
        f1lat = -1; f2lat = -1; nfd_b = 0;
        for (int i = 1; i <= 420; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if_b.wr_uart) begin
                if (i <= 244) q_b.push_back(u_if_b.w_data);
                else if (f2lat < 0) f2lat = i;
                if (f1lat < 0) f1lat = i;
            end
            if (frame_done_b) begin
                nfd_b++;
                check("p100_done_cycle", i, 244);
            end
            if (i == 199) check("p100_overrun_pre", overrun_b, 1'b0);
            if (i == 200) check("p100_overrun_set", overrun_b, 1'b1);
            if (i == 245) check("p100_busy_fell", busy_b, 1'b0);
            if (i == 420) check("p100_overrun_sticky", overrun_b, 1'b1);
        end
        check("p100_f1_first_write", f1lat, 101);
        check("p100_f2_first_write", f2lat, 301);
        check("p100_frame_done_count", nfd_b, 1);
        check_frame("p100", q_b, FRAME_LEN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
